// File: rtl/syn_md_lock_monitor_pkg.sv
// Shared types and constants for the sync/MD pulse lock monitor.
// Holds the FSM state encoding, counter widths and the lock-count helper.
package syn_md_lock_monitor_pkg;

    localparam int unsigned PERIOD_W = 16;
    localparam logic [PERIOD_W-1:0] SAT = 16'hFFFF;
    localparam int unsigned LOCK_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEAS,
        ST_LOCK
    } mon_state_t;

    // A request of zero still needs one good period before lock.
    function automatic logic [LOCK_W-1:0] eff_lock_req(input logic [LOCK_W-1:0] req);
        return (req == '0) ? LOCK_W'(1) : req;
    endfunction

endpackage

// File: rtl/syn_md_lock_monitor_sync_edge.sv
// Two-flop synchronizer plus history flop; flags rising edges of din.
// An input already high when reset is released is not reported as an edge.
module syn_md_sync_edge (
    input  logic clkin,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic       meta_q;
    logic       sync_q;
    logic       hist_q;
    logic [2:0] prime_q;

    // prime_q gates detection until hist_q holds a synchronized sample
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            hist_q  <= 1'b0;
            prime_q <= '0;
        end else begin
            meta_q  <= din;
            sync_q  <= meta_q;
            hist_q  <= sync_q;
            prime_q <= {prime_q[1:0], 1'b1};
        end
    end

    assign rise = sync_q & ~hist_q & prime_q[2];

endmodule

// File: rtl/syn_md_lock_monitor.sv
// Measures the period of an asynchronous sync/MD pulse train and declares
// lock after a programmable run of in-range periods.
import syn_md_lock_monitor_pkg::*;

module syn_md_lock_monitor (
    input  logic                clkin,
    input  logic                rst,
    input  logic                en,
    input  logic                syn_md_out,
    input  logic [15:0]         period_min,
    input  logic [15:0]         period_max,
    input  logic [3:0]          lock_cnt_req,
    output logic                syn_md_pulse,
    output logic [15:0]         period_val,
    output logic                period_valid,
    output logic                locked,
    output logic                lost
);

    mon_state_t          state;
    logic                rise;
    logic [PERIOD_W-1:0] cnt;
    logic [LOCK_W-1:0]   good_cnt;
    logic [LOCK_W:0]     good_next;
    logic                in_range;
    logic                timeout;
    logic                good_hit;

    syn_md_sync_edge u_sync_edge (
        .clkin (clkin),
        .rst   (rst),
        .din   (syn_md_out),
        .rise  (rise)
    );

    // An inverted window (min > max) naturally yields no in-range value.
    always_comb begin
        in_range  = (cnt >= period_min) && (cnt <= period_max);
        timeout   = (cnt == SAT);
        good_next = {1'b0, good_cnt} + (LOCK_W+1)'(1);
        good_hit  = good_next >= {1'b0, eff_lock_req(lock_cnt_req)};
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            good_cnt     <= '0;
            period_val   <= '0;
            syn_md_pulse <= 1'b0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            lost         <= 1'b0;
        end else begin
            syn_md_pulse <= rise;
            period_valid <= 1'b0;
            lost         <= 1'b0;

            if (state != ST_IDLE) begin
                if (rise)
                    cnt <= PERIOD_W'(1);
                else if (!timeout)
                    cnt <= cnt + PERIOD_W'(1);
            end

            // locked follows LOCK one cycle late on entry but drops together with lost
            if (!en) begin
                state    <= ST_IDLE;
                good_cnt <= '0;
                locked   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        locked <= 1'b0;
                        state  <= ST_ARM;
                    end
                    ST_ARM: begin
                        locked <= 1'b0;
                        if (rise) begin
                            state    <= ST_MEAS;
                            good_cnt <= '0;
                        end
                    end
                    ST_MEAS: begin
                        locked <= 1'b0;
                        if (rise) begin
                            period_val   <= cnt;
                            period_valid <= 1'b1;
                            if (in_range) begin
                                good_cnt <= good_next[LOCK_W-1:0];
                                if (good_hit)
                                    state <= ST_LOCK;
                            end else begin
                                good_cnt <= '0;
                            end
                        end else if (timeout) begin
                            state    <= ST_ARM;
                            good_cnt <= '0;
                        end
                    end
                    ST_LOCK: begin
                        locked <= 1'b1;
                        if (rise) begin
                            period_val   <= cnt;
                            period_valid <= 1'b1;
                            if (!in_range) begin
                                lost     <= 1'b1;
                                locked   <= 1'b0;
                                state    <= ST_MEAS;
                                good_cnt <= '0;
                            end
                        end else if (timeout) begin
                            lost     <= 1'b1;
                            locked   <= 1'b0;
                            state    <= ST_ARM;
                            good_cnt <= '0;
                        end
                    end
                    default: begin
                        locked <= 1'b0;
                        state  <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
